// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage: register file, EX/WB operand forwarding, and the
// ID/EX pipeline register feeding the ALU slice array under valid/ready.

module alu_operand_fwd #(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       src,
   input  logic [WIDTH-1:0] rf_data,
   input  logic             ex_live,
   input  logic [2:0]       ex_rd,
   input  logic [WIDTH-1:0] ex_f,
   input  logic             wb_en,
   input  logic [2:0]       wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] val
);
   // Youngest producer wins; r0 is hardwired so it can never be forwarded.
   always_comb begin
      if (src == 3'd0)                      val = '0;
      else if (ex_live && ex_rd == src)     val = ex_f;
      else if (wb_en && wb_addr == src)     val = wb_data;
      else                                  val = rf_data;
   end
endmodule

module alu_operand_stage #(
   parameter int WIDTH = 8,
   parameter int NREG  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [2:0]       in_rs,
   input  logic [2:0]       in_rt,
   input  logic [2:0]       in_rd,
   input  logic [WIDTH-1:0] in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_c,
   output logic             out_cin,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [2:0]       out_rd,
   output logic             out_wen,
   input  logic [WIDTH-1:0] ex_f,
   input  logic             wb_en,
   input  logic [2:0]       wb_addr,
   input  logic [WIDTH-1:0] wb_data
);
   typedef struct packed {
      logic [2:0]       c;
      logic             cin;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       rd;
      logic             wen;
   } id_ex_t;

   logic [NREG-1:0][WIDTH-1:0] rf;
   logic [1:0][2:0]            src;
   logic [1:0][WIDTH-1:0]      opnd;
   id_ex_t                     id_ex, nxt;
   logic                       vld;

   assign src      = {in_rt, in_rs};
   assign in_ready = !vld || out_ready;

   for (genvar g = 0; g < 2; g++) begin : g_src
      alu_operand_fwd #(.WIDTH(WIDTH)) u_fwd (
         .src     (src[g]),
         .rf_data (rf[src[g]]),
         .ex_live (vld && id_ex.wen),
         .ex_rd   (id_ex.rd),
         .ex_f    (ex_f),
         .wb_en   (wb_en),
         .wb_addr (wb_addr),
         .wb_data (wb_data),
         .val     (opnd[g])
      );
   end

   always_comb begin
      nxt.c   = in_op[2:0];
      nxt.cin = (in_op[2:0] == 3'b001);  // SUB computes A + ~B + 1
      nxt.a   = opnd[0];
      nxt.b   = in_op[3] ? in_imm : opnd[1];
      nxt.rd  = in_rd;
      nxt.wen = (in_rd != 3'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld   <= 1'b0;
         id_ex <= '0;
         rf    <= '0;
      end else begin
         if (wb_en && wb_addr != 3'd0) rf[wb_addr] <= wb_data;
         if (in_ready) begin
            vld <= in_valid;
            if (in_valid) id_ex <= nxt;
         end
      end
   end

   assign out_valid = vld;
   assign out_c     = id_ex.c;
   assign out_cin   = id_ex.cin;
   assign out_a     = id_ex.a;
   assign out_b     = id_ex.b;
   assign out_rd    = id_ex.rd;
   assign out_wen   = id_ex.wen;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, function map, r0, forwarding
// priority, back-to-back dependency, stall and mid-stall reset.

module tb_alu_operand_stage;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_cin, out_wen, wb_en;
   logic [3:0] in_op;
   logic [2:0] in_rs, in_rt, in_rd, out_c, out_rd, wb_addr;
   logic [7:0] in_imm, out_a, out_b, ex_f, wb_data;
   int         pass = 0, total = 0;

   alu_operand_stage #(.WIDTH(8), .NREG(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_cin(out_cin),
      .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
      .ex_f(ex_f), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic [7:0] imm);
      in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b1; ex_f = 8'h00;
      drv(4'b0000, 3'd1, 3'd2, 3'd3, 8'hAB);
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'hAA;
      tick(); tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else pass++;
      total++; if ({out_c, out_cin, out_rd, out_wen} !== 8'h00)
         $display("FAIL rst_ctrl got %h exp 00", {out_c, out_cin, out_rd, out_wen}); else pass++;
      total++; if ({out_a, out_b} !== 16'h0000) $display("FAIL rst_ab got %h exp 0000", {out_a, out_b}); else pass++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", in_ready); else pass++;
      rst_n = 1'b1; wb_en = 1'b0; in_valid = 1'b0;
      for (int i = 1; i < 8; i++) begin
         drv(4'b0000, 3'(i), 3'(i), 3'd0, 8'h00);
         tick();
         total++; if ({out_a, out_b} !== 16'h0000)
            $display("FAIL rst_r%0d got %h exp 0000", i, {out_a, out_b}); else pass++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_func();
      wr(3'd1, 8'h05); wr(3'd2, 8'h03);
      drv(4'b0000, 3'd1, 3'd2, 3'd4, 8'h00);
      tick();
      total++; if ({out_valid, out_c, out_cin, out_a, out_b, out_rd, out_wen} !== {1'b1, 3'b000, 1'b0, 8'h05, 8'h03, 3'd4, 1'b1})
         $display("FAIL add got c=%b cin=%b a=%h b=%h rd=%0d wen=%b exp c=000 cin=0 a=05 b=03 rd=4 wen=1",
                  out_c, out_cin, out_a, out_b, out_rd, out_wen); else pass++;
      drv(4'b0001, 3'd1, 3'd2, 3'd0, 8'h00);
      tick();
      total++; if ({out_c, out_cin, out_a, out_b} !== {3'b001, 1'b1, 8'h05, 8'h03})
         $display("FAIL sub got c=%b cin=%b a=%h b=%h exp c=001 cin=1 a=05 b=03", out_c, out_cin, out_a, out_b); else pass++;
      drv(4'b1110, 3'd1, 3'd2, 3'd0, 8'h0F);
      tick();
      total++; if ({out_c, out_cin, out_a, out_b} !== {3'b110, 1'b0, 8'h05, 8'h0F})
         $display("FAIL andi got c=%b cin=%b a=%h b=%h exp c=110 cin=0 a=05 b=0f", out_c, out_cin, out_a, out_b); else pass++;
      in_valid = 1'b0;
   endtask

   task automatic test_r0();
      wr(3'd0, 8'hFF);
      drv(4'b0000, 3'd0, 3'd0, 3'd5, 8'h00);
      tick();
      total++; if ({out_a, out_b} !== 16'h0000) $display("FAIL r0_read got %h exp 0000", {out_a, out_b}); else pass++;
      drv(4'b0000, 3'd1, 3'd2, 3'd0, 8'h00);
      tick();
      total++; if (out_wen !== 1'b0) $display("FAIL rd0_wen got %b exp 0", out_wen); else pass++;
      ex_f = 8'h55;
      drv(4'b0000, 3'd0, 3'd0, 3'd0, 8'h00);
      tick();
      total++; if ({out_a, out_b} !== 16'h0000) $display("FAIL rd0_nofwd got %h exp 0000", {out_a, out_b}); else pass++;
      in_valid = 1'b0; ex_f = 8'h00;
   endtask

   task automatic test_fwd();
      wr(3'd3, 8'h10);
      ex_f = 8'h30;
      drv(4'b0000, 3'd3, 3'd0, 3'd0, 8'h00);
      tick();
      total++; if (out_a !== 8'h10) $display("FAIL fwd_file got %h exp 10", out_a); else pass++;
      drv(4'b0000, 3'd0, 3'd0, 3'd3, 8'h00);
      tick();
      drv(4'b0000, 3'd3, 3'd3, 3'd0, 8'h00);
      wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h20;
      tick();
      total++; if ({out_a, out_b} !== 16'h3030) $display("FAIL fwd_ex got %h exp 3030", {out_a, out_b}); else pass++;
      drv(4'b0000, 3'd3, 3'd0, 3'd0, 8'h00);
      wb_data = 8'h21;
      tick();
      total++; if (out_a !== 8'h21) $display("FAIL fwd_wb got %h exp 21", out_a); else pass++;
      wb_en = 1'b0;
      drv(4'b0000, 3'd3, 3'd0, 3'd0, 8'h00);
      tick();
      total++; if (out_a !== 8'h21) $display("FAIL fwd_rf_after_wb got %h exp 21", out_a); else pass++;
      in_valid = 1'b0; ex_f = 8'h00;
   endtask

   task automatic test_back_to_back();
      drv(4'b0010, 3'd1, 3'd2, 3'd6, 8'h00);
      tick();
      ex_f = 8'h77;
      drv(4'b0011, 3'd6, 3'd6, 3'd0, 8'h00);
      tick();
      total++; if ({out_c, out_a, out_b} !== {3'b011, 8'h77, 8'h77})
         $display("FAIL b2b got c=%b a=%h b=%h exp c=011 a=77 b=77", out_c, out_a, out_b); else pass++;
      in_valid = 1'b0; ex_f = 8'h00;
      tick();
   endtask

   task automatic test_stall();
      drv(4'b0010, 3'd1, 3'd2, 3'd7, 8'h00);
      tick();
      out_ready = 1'b0;
      drv(4'b0011, 3'd2, 3'd1, 3'd5, 8'h00);
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'h99;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b exp 0", in_ready); else pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({out_valid, out_c, out_a, out_b, out_rd} !== {1'b1, 3'b010, 8'h05, 8'h03, 3'd7})
            $display("FAIL stall_hold%0d got v=%b c=%b a=%h b=%h rd=%0d exp v=1 c=010 a=05 b=03 rd=7",
                     i, out_valid, out_c, out_a, out_b, out_rd); else pass++;
      end
      wb_en = 1'b0; out_ready = 1'b1;
      tick();
      total++; if ({out_valid, out_c, out_a, out_b, out_rd} !== {1'b1, 3'b011, 8'h03, 8'h99, 3'd5})
         $display("FAIL stall_release got v=%b c=%b a=%h b=%h rd=%0d exp v=1 c=011 a=03 b=99 rd=5",
                  out_valid, out_c, out_a, out_b, out_rd); else pass++;
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL bubble got %b exp 0", out_valid); else pass++;
   endtask

   task automatic test_mid_reset();
      drv(4'b0100, 3'd2, 3'd1, 3'd4, 8'h00);
      tick();
      out_ready = 1'b0;
      drv(4'b0101, 3'd1, 3'd2, 3'd3, 8'h00);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL midrst got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else pass++;
      total++; if ({out_c, out_a, out_b, out_rd} !== 17'h0) $display("FAIL midrst_fields got %h exp 0", {out_c, out_a, out_b, out_rd}); else pass++;
      out_ready = 1'b1;
      drv(4'b0000, 3'd1, 3'd2, 3'd0, 8'h00);
      tick();
      total++; if ({out_a, out_b} !== 16'h0000) $display("FAIL midrst_rf got %h exp 0000", {out_a, out_b}); else pass++;
      in_valid = 1'b0;
   endtask

   initial begin
      wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00; in_valid = 1'b0;
      in_op = 4'd0; in_rs = 3'd0; in_rt = 3'd0; in_rd = 3'd0; in_imm = 8'h00;
      test_reset();
      test_func();
      test_r0();
      test_fwd();
      test_back_to_back();
      test_stall();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
